// File: rtl/pci_arb_pkg.sv
// pci_arb_pkg: shared encodings and widths for the PCI bus arbiter.
package pci_arb_pkg;

  // OWNER is always a 4-bit index, enough for the largest supported master count.
  localparam int OWNER_W = 4;
  localparam int MAX_REQ = 16;

  // Width of the grant-timeout counter (timeout limit is 1..255).
  localparam int CNT_W = 8;

  // Arbiter states. PARK is only reachable when bus parking is compiled in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    PARK  = 2'd3
  } state_t;

endpackage

// File: rtl/pci_arb_rr_pick.sv
// pci_arb_rr_pick: combinational round-robin search. Starting one past the
// last owner and wrapping at NUM_REQ-1 back to 0, it returns the first
// master whose (active-high) request bit is set.
module pci_arb_rr_pick
  import pci_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWNER_W-1:0] last_owner,
  output logic [OWNER_W-1:0] next_idx,
  output logic               any_req
);

  // One extra bit so last_owner + offset cannot overflow before the wrap.
  localparam int IDX_W = OWNER_W + 1;

  logic [MAX_REQ-1:0] req_ext;
  logic [IDX_W-1:0]   idx;
  logic               found;

  // Walk offsets 1..NUM_REQ from the last owner; the first hit wins.
  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    next_idx               = last_owner;
    found                  = 1'b0;
    idx                    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = {1'b0, last_owner} + IDX_W'(i);
      if (idx >= IDX_W'(NUM_REQ)) begin
        idx = idx - IDX_W'(NUM_REQ);
      end
      if (!found && req_ext[idx[OWNER_W-1:0]]) begin
        next_idx = idx[OWNER_W-1:0];
        found    = 1'b1;
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/pci_arbiter.sv
// pci_arbiter: round-robin PCI bus arbiter with registered active-low
// grants, hidden arbitration during bus activity and a grant timeout that
// counts only idle bus clocks.
// Optional feature: define PCI_ARB_PARK_EN to park the bus on the last
// owner when nobody is requesting.
module pci_arbiter
  import pci_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int GNT_TIMEOUT = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_REQ-1:0] REQ,
  output logic [NUM_REQ-1:0] GNT,
  input  logic               FRAME,
  input  logic               IRDY,
  output logic [OWNER_W-1:0] OWNER,
  output logic               GNT_VALID
);

  state_t             state;
  state_t             state_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic [OWNER_W-1:0] owner_n;
  logic [OWNER_W-1:0] pick;
  logic               any_req;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_n;
  logic [CNT_W-1:0]   cnt_inc;
  logic               idle;
  logic               idle_d;
  logic               start;
  logic               owner_req;
  logic [NUM_REQ-1:0] req_act;
  logic [MAX_REQ-1:0] req_ext;

  // Active-low GNT pattern with only the given master's bit low.
  function automatic logic [NUM_REQ-1:0] grant_of(input logic [OWNER_W-1:0] idx);
    logic [NUM_REQ-1:0] g;
    for (int i = 0; i < NUM_REQ; i++) begin
      g[i] = (idx != OWNER_W'(i));
    end
    return g;
  endfunction

  // Bus observation: idle, transaction start and the current owner's request.
  always_comb begin
    idle                 = FRAME & IRDY;
    start                = ~FRAME & idle_d;
    req_act              = ~REQ;
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req_act;
    owner_req            = req_ext[OWNER];
    cnt_inc              = cnt + CNT_W'(1);
  end

  pci_arb_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req        (req_act),
    .last_owner (OWNER),
    .next_idx   (pick),
    .any_req    (any_req)
  );

  // Next-state, next-grant, next-owner and timeout counter decisions.
  always_comb begin
    state_n = state;
    gnt_n   = GNT;
    owner_n = OWNER;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        gnt_n = '1;
        if (any_req) begin
          state_n = GRANT;
          owner_n = pick;
          gnt_n   = grant_of(pick);
          cnt_n   = '0;
        end
`ifdef PCI_ARB_PARK_EN
        else begin
          state_n = PARK;
          gnt_n   = grant_of(OWNER);
        end
`endif
      end

      // Start beats withdrawal, which beats timeout. The grant is dropped on
      // the idle clock that brings the count to GNT_TIMEOUT, so the grant is
      // visible for exactly GNT_TIMEOUT idle clocks. OWNER is kept so the
      // next search skips past a master that timed out.
      GRANT: begin
        if (start) begin
          state_n = BUSY;
          gnt_n   = '1;
          cnt_n   = '0;
        end else if (!owner_req) begin
          state_n = IDLE;
          gnt_n   = '1;
          cnt_n   = '0;
        end else if (idle) begin
          if (cnt_inc == CNT_W'(GNT_TIMEOUT)) begin
            state_n = IDLE;
            gnt_n   = '1;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end

      // GNT is already all high here, so a hidden grant issued now still
      // leaves at least one all-high clock between two owners.
      BUSY: begin
        gnt_n = '1;
        if (any_req) begin
          state_n = GRANT;
          owner_n = pick;
          gnt_n   = grant_of(pick);
          cnt_n   = '0;
        end else if (idle) begin
          state_n = IDLE;
        end
      end

`ifdef PCI_ARB_PARK_EN
      PARK: begin
        if (start) begin
          state_n = BUSY;
          gnt_n   = '1;
        end else if (owner_req) begin
          state_n = GRANT;
          cnt_n   = '0;
        end else if (any_req) begin
          state_n = IDLE;
          gnt_n   = '1;
        end
      end
`endif

      default: begin
        state_n = IDLE;
        gnt_n   = '1;
        cnt_n   = '0;
      end
    endcase
  end

  // Arbiter state, registered grant outputs and timeout counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      GNT       <= '1;
      OWNER     <= '0;
      GNT_VALID <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      GNT       <= gnt_n;
      OWNER     <= owner_n;
      GNT_VALID <= ~&gnt_n;
      cnt       <= cnt_n;
    end
  end

  // One-clock history of bus idle, used to recognise a transaction start.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      idle_d <= 1'b0;
    end else begin
      idle_d <= idle;
    end
  end

endmodule

// File: doc/pci_arbiter.md
PCI_ARBITER -- requirements
Module: pci_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of bus masters (2..16).
REQ-002 Parameter GNT_TIMEOUT, default 16, is the number of idle-bus clocks a granted master has to start FRAME# before its grant is withdrawn (1..255).
REQ-003 CLK  input  1  PCI clock; every register samples on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 REQ  input  NUM_REQ  active-low per-master bus request.
REQ-006 GNT  output  NUM_REQ  active-low per-master grant; registered.
REQ-007 FRAME  input  1  active-low bus FRAME#, observed only.
REQ-008 IRDY  input  1  active-low bus IRDY#, observed only.
REQ-009 OWNER  output  4  index of the master holding or last holding the grant; registered.
REQ-010 GNT_VALID  output  1  high while any GNT bit is low; registered.

Function
REQ-011 Bus idle is defined as FRAME==1 and IRDY==1; idle_d is idle registered by one clock.
REQ-012 Transaction start is defined as FRAME==0 while idle_d==1.
REQ-013 States: IDLE, GRANT, BUSY, PARK (PARK exists only with the macro).
REQ-014 At most one GNT bit is low in any cycle.
REQ-015 Selection is round-robin: search starts at OWNER+1, wraps at NUM_REQ-1 to 0, and picks the first master with REQ low.
REQ-016 IDLE, any REQ low: select a master, load OWNER, drive its GNT low at the same edge, and move to GRANT; latency from REQ sampled low to GNT low is one clock.
REQ-017 IDLE, no REQ low: stay in IDLE with all GNT high.
REQ-018 GRANT, transaction start: move to BUSY and drive all GNT high.
REQ-019 GRANT, REQ[OWNER] high and no start: move to IDLE with all GNT high.
REQ-020 GRANT timeout: an 8-bit counter runs only on idle clocks and clears on entry to GRANT; at count GNT_TIMEOUT the block moves to IDLE, drives all GNT high, and keeps OWNER so the next search moves past that master.
REQ-021 GRANT, bus not idle (hidden grant): the counter holds.
REQ-022 BUSY, any REQ low: select the next master and move to GRANT (hidden arbitration); the granted master waits for the bus to go idle.
REQ-023 BUSY, no REQ low and bus idle: move to IDLE.
REQ-024 Any handover of GNT from one master to another passes through at least one clock with all GNT high.
REQ-025 Simultaneous events in GRANT: transaction start takes priority over REQ withdrawal and over timeout.
REQ-026 A REQ toggle on a non-owner in GRANT or BUSY has no effect until the next selection.
REQ-027 GNT_VALID equals ~&GNT, registered together with GNT.

Reset
REQ-028 Asserting RESET at any time, including mid-transaction, forces: state IDLE, GNT all ones, OWNER 0, GNT_VALID 0, timeout counter 0.
REQ-029 After RESET is released, the first grant decision is made at the first rising edge; the search starts at master 1.

Configuration
REQ-030 Macro PCI_ARB_PARK_EN enables bus parking.
REQ-031 With PCI_ARB_PARK_EN: IDLE with no REQ low moves to PARK, which drives GNT[OWNER] low with no timeout.
REQ-032 With PCI_ARB_PARK_EN: a transaction start in PARK moves to BUSY.
REQ-033 With PCI_ARB_PARK_EN: REQ[OWNER] low in PARK moves to GRANT and keeps the grant.
REQ-034 With PCI_ARB_PARK_EN: another master's REQ low in PARK moves to IDLE with all GNT high for one clock, then arbitrates normally.
REQ-035 Without PCI_ARB_PARK_EN: the PARK state and its logic are absent, and the bus is never granted with no requester.

Structure
REQ-036 Package pci_arb_pkg holds the state encodings (IDLE, GRANT, BUSY, PARK), the OWNER width, and the timeout counter width.
REQ-037 The round-robin search is the combinational sub-module pci_arb_rr_pick (inputs: request vector, last owner; outputs: next index, any_req); the FSM, counter and GNT registers stay in pci_arbiter.

Verification
REQ-038 NUM_REQ=4, REQ=1110 held, master 0 drives FRAME low 2 clocks after GNT -> GNT=1110 one clock after REQ sampled, then GNT=1111 on FRAME start, OWNER=0.
REQ-039 REQ=0000 held, each master runs one single-data-phase transaction -> grant order 1,2,3,0,1, every handover has one or more all-ones GNT clocks, and no two GNT bits are ever low together.
REQ-040 GNT_TIMEOUT=16, master 2 requests and never drives FRAME -> GNT[2] low for exactly 16 idle clocks, then 1111; with master 3 also requesting, the next grant goes to master 3.
REQ-041 Master 1 in a transaction, master 3 requests -> GNT=0111 asserted during BUSY; master 3 starts only after FRAME and IRDY both read 1; the counter does not advance while the bus is busy.
REQ-042 RESET pulsed while GNT=1011 and FRAME low -> GNT=1111, OWNER=0, GNT_VALID=0 immediately, without waiting for a clock edge.
REQ-043 PCI_ARB_PARK_EN defined, no requests after master 2 finishes -> GNT=1011 held indefinitely; master 0 then requests -> one clock of 1111, then 1110.
